mux3_sel_arbiter: RTL and testbench
===================================

Name: mux3_sel_arbiter

Overview:
- Upstream control stage for the 3-input select mux (i0/i1/i2, selects s0/s1, s0 has priority).
- Arbitrates three requesters round-robin and drives s0/s1 so that the granted channel's data reaches y.
- Holds a grant until the owner releases it, then inserts one idle guard cycle before re-arbitrating.
- Guarantees the select pair is never 11.

Parameters:
- MAX_HOLD, 16: maximum consecutive GRANT cycles for one owner. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.
- CNT_W, 8: hold counter width. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req  input  3  request per channel; bit k requests mux input ik.
- done  input  1  owner releases the grant; sampled only in GRANT.
- grant  output  3  one-hot grant, registered.
- s0  output  1  mux select bit 0, registered.
- s1  output  1  mux select bit 1, registered.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse on forced release. Tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, grant=000, s0=0, s1=0, busy=0, timeout=0, hold_cnt=0, last=2 (channel 0 has first priority). Reset mid-GRANT drops the grant the same edge; no guard cycle.
- Select encoding (registered together with grant, same edge):
  - ch0 -> s1s0=00
  - ch1 -> s1s0=01
  - ch2 -> s1s0=10
  - IDLE -> 00
  - 11 is never driven.
- IDLE:
  - If req!=0, the winner is the first set bit scanning last+1, last+2, last+3 (mod 3).
  - Next edge: state=GRANT, grant=onehot(winner), selects per encoding, busy=1, hold_cnt=1, last=winner.
  - Latency is one cycle from req sampled high to grant visible.
- GRANT (owner g):
  - Remains while req[g]=1 and done=0. Requests from other channels are ignored.
  - Releases when done=1 or req[g]=0. Next edge: state=IDLE, grant=000, s1s0=00, busy=0.
  - The IDLE cycle is a mandatory guard cycle, so arbitration resumes one cycle later. A back-to-back handover therefore has exactly 1 dead cycle.
- hold_cnt increments each GRANT cycle and saturates at 2**CNT_W-1.
- If done and a new req arrive in the same cycle: release takes effect first. The new req wins arbitration in the guard IDLE cycle and is granted on the following edge.
- If req[g] and done are both high: treated as a release.
- Round robin: with all three requesting continuously, the grant order is 0,1,2,0,...
- Invariants: grant is one-hot or zero; busy equals |grant; the selects always match grant.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD and no release is present, force a release on the next edge.
  - timeout pulses 1 for exactly the cycle the FSM is in the guard IDLE. The owner must re-request and waits its round-robin turn.
  - last=g, so other requesters go first.
- Undefined:
  - The grant is held indefinitely.
  - timeout is constant 0 and the comparison logic is absent.

Decomposition:
- Package mux3_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - channel index constants CH0=0, CH1=1, CH2=2
  - select encoding constants SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10
- One sub-module, rr_pick3: combinational round-robin winner from (req, last). Outputs winner index and valid.
- The FSM, hold counter and output registers live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=111 -> grant=000, s1s0=00, busy=0. First grant after release of reset is ch0 (grant=001, s1s0=00, busy=1) one cycle after rst_n=1.
- Single request: req=010 at cycle t -> grant=010, s1s0=01 at t+1. Assert done at t+4 -> grant=000, s1s0=00 at t+5.
- Fairness: req=111 held and done pulsed every 3rd cycle -> grant sequence 001,000,010,000,100,000,001. s1s0 is never 11.
- Simultaneous events: ch0 granted; at cycle t, done=1 and req=101 -> guard IDLE at t+1, grant=100 (s1s0=10) at t+2.
- Reset mid-grant: ch2 granted, rst_n=0 for one cycle -> next edge grant=000, last=2. With req=111, the next grant is ch0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=011 held, done=0 -> ch0 is granted, then released after 4 GRANT cycles with a timeout pulse of 1 cycle. Ch1 is granted next. Without the macro, ch0 stays granted for 100 cycles.

Source files
------------

// File: rtl/mux3_arb_pkg.sv
// mux3_arb_pkg: shared types and constants for the 3-input select-mux arbiter.
//   state_e       : arbiter FSM states (IDLE, GRANT)
//   CH0..CH2      : channel indices
//   SEL_CH0..2    : {s1,s0} encodings per channel (11 is never used)
//   onehot3/sel_of: helpers mapping a channel index to grant / select values
package mux3_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;

  function automatic logic [2:0] onehot3(input logic [1:0] ch);
    case (ch)
      CH0:     onehot3 = 3'b001;
      CH1:     onehot3 = 3'b010;
      CH2:     onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  // Unknown index maps to SEL_CH0 so the 11 pattern can never escape.
  function automatic logic [1:0] sel_of(input logic [1:0] ch);
    case (ch)
      CH1:     sel_of = SEL_CH1;
      CH2:     sel_of = SEL_CH2;
      default: sel_of = SEL_CH0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational round-robin winner for three requesters.
//   req_i    [2:0] request vector
//   last_i   [1:0] channel granted most recently
//   winner_o [1:0] first requester scanning last+1, last+2, last+3 (mod 3)
//   valid_o        any request present
module rr_pick3
  import mux3_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] winner_o,
  output logic       valid_o
);

  logic [1:0] o0, o1, o2;

  always_comb begin
    o0 = CH0;
    o1 = CH1;
    o2 = CH2;
    case (last_i)
      CH0: begin o0 = CH1; o1 = CH2; o2 = CH0; end
      CH1: begin o0 = CH2; o1 = CH0; o2 = CH1; end
      default: begin o0 = CH0; o1 = CH1; o2 = CH2; end
    endcase
  end

  always_comb begin
    valid_o  = |req_i;
    winner_o = o2;
    if (req_i[o0])      winner_o = o0;
    else if (req_i[o1]) winner_o = o1;
  end

endmodule

// File: rtl/mux3_sel_arbiter.sv
// mux3_sel_arbiter: round-robin arbiter driving the select pair of a 3-input
// mux (s0 has priority in the mux). A grant is held until the owner releases
// it (done, or its request drops); the following IDLE cycle is a guard cycle
// during which the next winner is picked.
//   clk, rst_n     clock, synchronous active-low reset
//   req   [2:0]    per-channel request
//   done           owner release, sampled only in GRANT
//   grant [2:0]    registered one-hot grant
//   s0, s1         registered mux selects, {s1,s0} never 11
//   busy           high while in GRANT
//   timeout        one-cycle pulse in the guard cycle after a forced release
// Optional: define ARB_TIMEOUT_EN to force release after MAX_HOLD GRANT
// cycles; otherwise timeout is constant 0 and the grant is held indefinitely.
module mux3_sel_arbiter
  import mux3_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("mux3_sel_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  state_e           state_q;
  logic [2:0]       grant_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [1:0]       last_q;

  logic [1:0] win;
  logic       win_vld;
  logic       release_d;
  logic       force_rel_d;

  rr_pick3 u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (win),
    .valid_o  (win_vld)
  );

  // grant_q is one-hot, so masking req with it yields the owner's request.
  always_comb begin
    release_d  = done | ~|(req & grant_q);
    hold_cnt_d = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q : hold_cnt_q + 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  // A genuine release in the same cycle takes precedence and is not a timeout.
  assign force_rel_d = (hold_cnt_q == CNT_W'(MAX_HOLD)) & ~release_d;
`else
  assign force_rel_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 3'b000;
      sel_q      <= SEL_CH0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= CH2;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (win_vld) begin
            state_q    <= GRANT;
            grant_q    <= onehot3(win);
            sel_q      <= sel_of(win);
            busy_q     <= 1'b1;
            hold_cnt_q <= CNT_W'(1);
            last_q     <= win;
          end
        end
        GRANT: begin
          if (release_d || force_rel_d) begin
            // last_q keeps the owner, so other requesters go first next time.
            state_q    <= IDLE;
            grant_q    <= 3'b000;
            sel_q      <= SEL_CH0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            timeout_q  <= force_rel_d;
          end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 3'b000;
          sel_q   <= SEL_CH0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign s0      = sel_q[0];
  assign s1      = sel_q[1];
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux3_sel_arbiter.sv
module tb_mux3_sel_arbiter;

  localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [2:0] grant;
  logic       s0, s1, busy, timeout;

  int checks = 0;
  int errors = 0;

  // Reference: owner = -1 when idle.
  int m_owner = -1;
  int m_last  = 2;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  mux3_sel_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .s0(s0), .s1(s1), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] rq, input logic d);
    bit rel, frc;
    if (!r) begin
      m_owner = -1; m_last = 2; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (rq[c]) begin
          m_owner = c; m_last = c; m_hold = 1;
          break;
        end
      end
    end else begin
      rel = d || !rq[m_owner];
      frc = TO_EN && (m_hold == MAXH) && !rel;
      if (rel || frc) begin
        m_owner = -1; m_hold = 0; m_to = frc;
      end else begin
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        m_to = 1'b0;
      end
    end
  endtask

  // One clock: drive, update model, then sample 1ns after the edge.
  task automatic cyc(input logic r, input logic [2:0] rq, input logic d);
    logic [2:0] eg;
    rst_n = r; req = rq; done = d;
    @(posedge clk);
    model_step(r, rq, d);
    #1;
    eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    chk("grant", {5'b0, grant}, {5'b0, eg});
    chk("sel", {6'b0, s1, s0}, (m_owner < 0) ? 8'd0 : 8'(m_owner));
    chk("busy", {7'b0, busy}, {7'b0, m_owner >= 0});
    chk("timeout", {7'b0, timeout}, {7'b0, m_to});
    chk("sel_not_11", {7'b0, s1 & s0}, 8'd0);
  endtask

  initial begin
    logic [2:0] runs[$];
    logic [2:0] fexp[7];
    logic [2:0] g_hist[8];
    logic       t_hist[8];
    int bad;
    fexp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

    // Reset with all requesting, then first grant goes to ch0.
    cyc(1'b0, 3'b111, 1'b0);
    cyc(1'b0, 3'b111, 1'b0);
    chk("rst_grant", {5'b0, grant}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    cyc(1'b1, 3'b111, 1'b0);
    chk("first_grant", {5'b0, grant}, 8'h01);
    cyc(1'b1, 3'b000, 1'b0);

    // Single request on ch1, released by done four cycles later.
    cyc(1'b1, 3'b010, 1'b0);
    chk("single_grant", {5'b0, grant}, 8'h02);
    chk("single_sel", {6'b0, s1, s0}, 8'h01);
    repeat (3) cyc(1'b1, 3'b010, 1'b0);
    cyc(1'b1, 3'b010, 1'b1);
    chk("single_rel", {5'b0, grant}, 8'h00);

    // Fairness: all requesting, done every 3rd cycle.
    cyc(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 3'b111, (i % 3) == 2);
      if (runs.size() == 0 || runs[$] != grant) runs.push_back(grant);
    end
    chk("fair_len_ok", {7'b0, runs.size() >= 7}, 8'h01);
    for (int i = 0; i < 7; i++)
      if (i < runs.size()) chk($sformatf("fair_seq%0d", i), {5'b0, runs[i]}, {5'b0, fexp[i]});

    // Release and new request in the same cycle.
    cyc(1'b0, 3'b000, 1'b0);
    cyc(1'b1, 3'b001, 1'b0);
    chk("sim_ch0", {5'b0, grant}, 8'h01);
    cyc(1'b1, 3'b101, 1'b1);
    chk("sim_guard", {5'b0, grant}, 8'h00);
    cyc(1'b1, 3'b101, 1'b0);
    chk("sim_ch2", {5'b0, grant}, 8'h04);
    chk("sim_ch2_sel", {6'b0, s1, s0}, 8'h02);

    // Reset mid-grant drops the grant immediately and restores last=2.
    cyc(1'b0, 3'b111, 1'b0);
    chk("midrst_grant", {5'b0, grant}, 8'h00);
    cyc(1'b1, 3'b111, 1'b0);
    chk("midrst_next", {5'b0, grant}, 8'h01);

    // Hold limit.
    cyc(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'b011, 1'b0);
      g_hist[i] = grant;
      t_hist[i] = timeout;
    end
    if (TO_EN) begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (g_hist[i] != 3'b001 || t_hist[i]) bad++;
      chk("to_hold4", 8'(bad), 8'd0);
      chk("to_guard", {5'b0, g_hist[4]}, 8'h00);
      chk("to_pulse", {7'b0, t_hist[4]}, 8'h01);
      chk("to_next_ch1", {5'b0, g_hist[5]}, 8'h02);
      chk("to_pulse_end", {7'b0, t_hist[5]}, 8'h00);
    end else begin
      bad = 0;
      for (int i = 0; i < 92; i++) begin
        cyc(1'b1, 3'b011, 1'b0);
        if (grant != 3'b001 || timeout) bad++;
      end
      for (int i = 0; i < 8; i++) if (g_hist[i] != 3'b001 || t_hist[i]) bad++;
      chk("hold100", 8'(bad), 8'd0);
    end

    // Random traffic against the reference.
    cyc(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 60) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
